// File: rtl/program_loader_if.sv
// Host/program-memory/CPU-control bundle for the program loader.
interface program_loader_if #(
    parameter int ADD_WIDTH  = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  load_start;
    logic [ADD_WIDTH:0]    load_len;
    logic                  byte_valid;
    logic [DATA_WIDTH-1:0] byte_in;
    logic                  byte_ready;
    logic                  pm_wr_en;
    logic [ADD_WIDTH-1:0]  pm_addr;
    logic [DATA_WIDTH-1:0] pm_data;
    logic                  cpu_rst;
    logic                  load_done;
    logic                  load_err;

    modport master (
        output load_start, load_len, byte_valid, byte_in,
        input  byte_ready, pm_wr_en, pm_addr, pm_data,
        input  cpu_rst, load_done, load_err
    );

    modport slave (
        input  load_start, load_len, byte_valid, byte_in,
        output byte_ready, pm_wr_en, pm_addr, pm_data,
        output cpu_rst, load_done, load_err
    );
endinterface

// File: rtl/program_loader.sv
// Streams a host image into program memory, verifies an additive
// checksum, then releases the CPU from reset.
module program_loader #(
    parameter int ADD_WIDTH  = 7,
    parameter int DATA_WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    program_loader_if.slave  bus
);
    localparam int LW = ADD_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, CHECK, RUN, ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  pm_wr_en_q, pm_wr_en_d;
    logic [ADD_WIDTH-1:0]  pm_addr_q, pm_addr_d;
    logic [DATA_WIDTH-1:0] pm_data_q, pm_data_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
    logic                  cpu_rst_q, cpu_rst_d;

    logic byte_ready;
    logic accept;
    logic last;

    assign byte_ready = (state_q == LOAD) || (state_q == CHECK);
    assign accept     = byte_ready && bus.byte_valid;
    // Counter is one bit wider than the address so a full image never wraps.
    assign last       = (cnt_q + LW'(1)) == len_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        pm_wr_en_d  = 1'b0;
        pm_addr_d   = pm_addr_q;
        pm_data_d   = pm_data_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;
        case (state_q)
            IDLE, RUN, ERROR: begin
                if (bus.load_start) begin
                    len_d      = bus.load_len;
                    cnt_d      = '0;
                    sum_d      = '0;
                    load_err_d = 1'b0;
                    state_d    = (bus.load_len == '0) ? CHECK : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    pm_wr_en_d = 1'b1;
                    pm_addr_d  = cnt_q[ADD_WIDTH-1:0];
                    pm_data_d  = bus.byte_in;
                    sum_d      = sum_q + bus.byte_in;
                    cnt_d      = cnt_q + LW'(1);
                    if (last) state_d = CHECK;
                end
            end
            CHECK: begin
                if (accept) begin
                    if (bus.byte_in == sum_q) begin
                        state_d     = RUN;
                        load_done_d = 1'b1;
                    end else begin
                        state_d    = ERROR;
                        load_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cpu_rst_d = (state_d != RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            pm_wr_en_q  <= 1'b0;
            pm_addr_q   <= '0;
            pm_data_q   <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            cpu_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            pm_wr_en_q  <= pm_wr_en_d;
            pm_addr_q   <= pm_addr_d;
            pm_data_q   <= pm_data_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            cpu_rst_q   <= cpu_rst_d;
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.pm_wr_en   = pm_wr_en_q;
    assign bus.pm_addr    = pm_addr_q;
    assign bus.pm_data    = pm_data_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_err   = load_err_q;
    assign bus.cpu_rst    = cpu_rst_q;
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADD_WIDTH, default 7, program-memory byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, program-memory write data width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; port list follows.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 load_start  input  1  single-cycle request to begin a program load.
REQ-007 load_len  input  ADD_WIDTH+1  byte count of the image (0..2^ADD_WIDTH), sampled with load_start.
REQ-008 byte_valid  input  1  host byte present on byte_in.
REQ-009 byte_in  input  DATA_WIDTH  host byte (image bytes, then one checksum byte).
REQ-010 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-011 pm_wr_en  output  1  program-memory write strobe.
REQ-012 pm_addr  output  ADD_WIDTH  program-memory write address.
REQ-013 pm_data  output  DATA_WIDTH  program-memory write data.
REQ-014 cpu_rst  output  1  reset to downstream CPU core; high = CPU held in reset.
REQ-015 load_done  output  1  one-cycle pulse on successful load.
REQ-016 load_err  output  1  level; checksum mismatch, held until next load_start or rst.

Function
REQ-017 SHALL implement states IDLE, LOAD, CHECK, RUN, ERROR.
REQ-018 Handshake: byte accepted when byte_valid and byte_ready are both high on a rising edge; byte_ready = 1 only in LOAD and CHECK.
REQ-019 IDLE/RUN/ERROR + load_start: go to LOAD; latch load_len; clear address counter, running sum, load_err; cpu_rst = 1 from the next cycle.
REQ-020 IDLE/RUN/ERROR + load_start with load_len = 0: go directly to CHECK, sum = 0.
REQ-021 load_start in LOAD or CHECK SHALL be ignored.
REQ-022 LOAD: each accepted byte SHALL produce, next cycle, pm_wr_en = 1 for exactly one cycle with pm_addr = byte index (0, 1, 2, ...) and pm_data = the byte.
REQ-023 LOAD: running sum = (sum + byte) mod 2^DATA_WIDTH per accepted byte.
REQ-024 LOAD: on acceptance of byte number load_len (last), go to CHECK next cycle.
REQ-025 With load_len = 2^ADD_WIDTH, last write SHALL use pm_addr = 2^ADD_WIDTH-1; address counter SHALL NOT wrap to 0 inside one load.
REQ-026 CHECK: accepted byte is the checksum, never written (pm_wr_en stays 0).
REQ-027 CHECK: checksum == running sum -> RUN next cycle, load_done pulses that cycle, cpu_rst = 0 from that cycle.
REQ-028 CHECK: checksum != running sum -> ERROR next cycle, load_err = 1, cpu_rst stays 1.
REQ-029 cpu_rst SHALL be registered, = 1 in IDLE, LOAD, CHECK, ERROR; = 0 only in RUN.
REQ-030 pm_wr_en, pm_addr, pm_data, load_done SHALL be registered; pm_addr/pm_data hold last values when pm_wr_en = 0.
REQ-031 Back-to-back valid bytes SHALL be accepted one per cycle with no bubble.

Reset
REQ-032 rst asserted SHALL immediately force state IDLE, cpu_rst = 1, byte_ready = 0, pm_wr_en = 0, pm_addr = 0, pm_data = 0, load_done = 0, load_err = 0, counter and sum = 0.
REQ-033 rst during LOAD or CHECK SHALL abort the load; already-issued writes are not undone; no pending write is issued after rst.
REQ-034 After rst deasserts, the block SHALL remain in IDLE until load_start.

Verification
REQ-035 Load len=4, bytes 0x13,0x05,0x10,0x00, checksum 0x28 -> writes addr 0..3 with those bytes, load_done one pulse, cpu_rst falls, load_err = 0.
REQ-036 Same image, checksum 0x29 -> ERROR, load_err = 1, cpu_rst stays 1, no write on checksum byte.
REQ-037 len=128, bytes 0xFF each, checksum 0x80 -> last write addr 127, no wrap, RUN reached.
REQ-038 byte_valid toggled 1-0-1 during LOAD -> writes only on accepted cycles, addresses contiguous.
REQ-039 rst pulsed after 2 of 4 bytes -> all outputs at reset values, byte_ready = 0 until next load_start; fresh load starts at addr 0.
REQ-040 load_start in RUN with len=0 and checksum 0x00 -> cpu_rst high for CHECK, then RUN, load_done pulse, zero writes.
